// File: rtl/encrypt_out_queue_pkg.sv
// encrypt_out_queue_pkg: shared widths and occupancy helpers for the DES output queue.
// Optional arrival tagging is enabled with ENCRYPT_OUT_QUEUE_SEQ_EN.
`ifndef N_B
`define N_B 64
`endif
`ifndef N_Q
`define N_Q 8
`endif
`ifndef N_SEQ
`define N_SEQ 16
`endif

package encrypt_out_queue_pkg;

   localparam int SEQ_W = `N_SEQ;

   typedef struct packed {
      logic push;
      logic pop;
      logic drop;
   } q_op_t;

   typedef enum logic [1:0] {
      OCC_EMPTY,
      OCC_PARTIAL,
      OCC_FULL
   } occ_t;

   function automatic occ_t occ_of(input int unsigned cnt,
                                   input int unsigned depth);
      occ_t o;
      if (cnt == 0)
         o = OCC_EMPTY;
      else if (cnt >= depth)
         o = OCC_FULL;
      else
         o = OCC_PARTIAL;
      return o;
   endfunction

endpackage

// File: rtl/encrypt_out_queue_mem.sv
// encrypt_out_queue_mem: DEPTH x W register file.
// One synchronous write port, one asynchronous read port; contents are not reset.
module encrypt_out_queue_mem #(
   parameter int DEPTH = 8,
   parameter int W     = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [W-1:0]             rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/encrypt_out_queue.sv
// encrypt_out_queue: buffers DES ciphertext strobes for a valid/ready consumer.
// Define ENCRYPT_OUT_QUEUE_SEQ_EN to add per-block arrival tags on out_seq.
module encrypt_out_queue
   import encrypt_out_queue_pkg::*;
#(
   parameter int DEPTH = `N_Q,
   parameter int W     = `N_B
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [W-1:0]           in_c,
   input  logic                   flush,
   output logic                   out_valid,
   output logic [W-1:0]           out_c,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   overflow
`ifdef ENCRYPT_OUT_QUEUE_SEQ_EN
   ,
   output logic [SEQ_W-1:0]       out_seq
`endif
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] rptr;
   logic [AW-1:0] wptr;
   logic [W-1:0]  rd_c;
   occ_t          occ;
   q_op_t         op;

   // A full queue still accepts a block when the head leaves in the same cycle.
   always_comb begin
      op      = '0;
      occ     = occ_of(32'(count), DEPTH);
      op.pop  = (occ != OCC_EMPTY) && out_ready;
      op.push = in_valid && ((occ != OCC_FULL) || op.pop);
      op.drop = in_valid && (occ == OCC_FULL) && !op.pop;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rptr     <= '0;
         wptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         rptr     <= '0;
         wptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (op.push)
            wptr <= wptr + 1'b1;
         if (op.pop)
            rptr <= rptr + 1'b1;
         unique case (1'b1)
            op.push && !op.pop: count <= count + 1'b1;
            op.pop && !op.push: count <= count - 1'b1;
            default: ;
         endcase
         if (op.drop)
            overflow <= 1'b1;
      end
   end

   encrypt_out_queue_mem #(
      .DEPTH (DEPTH),
      .W     (W)
   ) u_data (
      .clk   (clk),
      .we    (op.push && !flush),
      .waddr (wptr),
      .wdata (in_c),
      .raddr (rptr),
      .rdata (rd_c)
   );

   assign out_valid = (occ != OCC_EMPTY);
   assign full      = (occ == OCC_FULL);
   assign out_c     = out_valid ? rd_c : '0;

`ifdef ENCRYPT_OUT_QUEUE_SEQ_EN
   logic [SEQ_W-1:0] seq_q;
   logic [SEQ_W-1:0] tag_rd;

   // Counts every strobe, dropped or not, so losses show up as tag gaps.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         seq_q <= '0;
      else if (flush)
         seq_q <= '0;
      else if (in_valid)
         seq_q <= seq_q + 1'b1;
   end

   encrypt_out_queue_mem #(
      .DEPTH (DEPTH),
      .W     (SEQ_W)
   ) u_tag (
      .clk   (clk),
      .we    (op.push && !flush),
      .waddr (wptr),
      .wdata (seq_q),
      .raddr (rptr),
      .rdata (tag_rd)
   );

   assign out_seq = out_valid ? tag_rd : '0;
`endif

endmodule

// File: doc/encrypt_out_queue.md
Name: encrypt_out_queue

Overview:
- Downstream stage of the pipelined DES encryptor.
- Captures each ciphertext block the pipeline emits as a one-cycle strobe; the pipeline has no backpressure.
- Buffers blocks in arrival order and presents them to the consumer over a valid/ready handshake.
- Detects and flags blocks lost to overflow.

Parameters:
- DEPTH, default 8: number of ciphertext entries; must be a power of two, >= 2.
- W, default `N_B (64): ciphertext width in bits.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low; 0 = reset.
- in_valid  input  1  pipeline strobe: in_c holds a finished block this cycle.
- in_c  input  W  ciphertext from the pipeline.
- flush  input  1  synchronous clear of the queue contents.
- out_valid  output  1  head entry is available.
- out_c  output  W  head entry; all zeros when out_valid=0.
- out_ready  input  1  consumer accepts the head this cycle.
- count  output  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky flag: at least one block was dropped.

Behaviour:
- Reset (rst=0, asynchronous):
  - Read pointer, write pointer and count go to 0.
  - out_valid=0, out_c=0, full=0, overflow=0.
  - Storage array is not reset.
- Pointers:
  - Width $clog2(DEPTH); wrap naturally from DEPTH-1 to 0.
  - count is tracked separately so full and empty are unambiguous.
- Push: occurs when in_valid=1 and (count<DEPTH, or a pop occurs in the same cycle).
  - Writes in_c at the write pointer; write pointer advances by 1.
- Pop: occurs when out_valid=1 and out_ready=1; read pointer advances by 1.
- Same-cycle push and pop: count unchanged. This applies at full as well; the incoming block is accepted.
- Pop at empty: out_ready is ignored; no state change.
- Drop: in_valid=1, count==DEPTH and no pop in that cycle.
  - in_c is discarded and overflow is set to 1.
  - overflow stays 1 until reset or flush.
- flush=1:
  - Next edge sets pointers, count and overflow to 0.
  - Overrides any push or pop in the same cycle; a block strobed in that cycle is discarded and does not set overflow.
- Latency: a block pushed at edge N appears on out_c with out_valid=1 after edge N, and not before. There is no combinational in-to-out bypass.
- Outputs:
  - out_valid = (count != 0). full and overflow are registered or derived from registered count; no combinational path from any input.
  - out_c is the combinational read of storage at the read pointer, gated to zero when empty.
- Ordering: strict FIFO. The k-th accepted block is the k-th block popped.
- Occupancy states, derived from count (no separate state register):
  - EMPTY (count=0): push → PARTIAL, or → FULL if DEPTH=1 (not permitted).
  - PARTIAL: push only → count+1; pop only → count-1; both → unchanged.
  - FULL: pop → PARTIAL; push without pop → drop.
- Reset asserted mid-operation: all entries are lost and no outputs glitch beyond the immediate clear.

Optional Feature:
- Macro: ENCRYPT_OUT_QUEUE_SEQ_EN.
- With the macro defined:
  - Adds output out_seq [15:0] and a 16-bit arrival counter.
  - The counter increments on every in_valid strobe, whether accepted or dropped; it wraps at 65535 → 0 and is cleared by reset and flush.
  - Each accepted block stores the counter value alongside it, and out_seq presents the head's tag.
  - Consumers detect drops as gaps in out_seq.
- Without the macro: no port, no counter, no tag storage.

Decomposition:
- Shared header params.h (alongside `N_B, `N_V, `N_R):
  - Add `N_Q, the default queue depth (8).
  - Add `N_SEQ, the tag width (16).
- Sub-module encrypt_out_queue_mem:
  - DEPTH x W register file with one synchronous write port and one asynchronous read port.
  - Reused for the tag array under ENCRYPT_OUT_QUEUE_SEQ_EN.

Test Plan:
- Reset: rst=0 mid-run with count=5 → next sample shows count=0, out_valid=0, out_c=64'h0, overflow=0; after rst=1, push 64'h85E813540F0AB405 → out_valid=1 one cycle later with that value.
- Order: push 0x1,0x2,0x3 on consecutive cycles with out_ready=0, then out_ready=1 → pops return 0x1,0x2,0x3 on three consecutive cycles, then out_valid=0.
- Full/drop (DEPTH=8): 9 consecutive pushes of 0x10..0x18, out_ready=0 → full=1, count=8, overflow=1; draining yields 0x10..0x17 only.
- Full with simultaneous pop: queue full, out_ready=1, push 0xAA in the same cycle → head popped, 0xAA accepted, count stays 8, overflow stays 0.
- Wrap and flush: 20 push/pop pairs at count=3 → order preserved across wrap; flush asserted with in_valid=1 → count=0, overflow=0, pushed block absent.
- Sequence tags (macro on): 10 strobes into a full queue with out_ready=0 after 8 accepted → out_seq on drain reads 0..7; next accepted strobe carries tag 10.
